// File: rtl/mem_stage_access.sv
// ==========================================================================
// mem_stage_access : MEM stage; data-memory req/ack access plus MEM/WB regs
// Revision 1.0
// ==========================================================================
`default_nettype none

module mem_stage_access #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [4:0]        Dest_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              valid_out,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       Mem_read_value,
  output logic [4:0]        Dest,
  output logic [1:0]        err
);

  localparam logic [0:0]       c_IDLE     = 1'b0;
  localparam logic [0:0]       c_ACCESS   = 1'b1;
  localparam int               c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;

  logic        r_h_wb;
  logic        r_h_mr;
  logic [31:0] r_h_alu;
  logic [4:0]  r_h_dest;

  // Only the low ADDR_W+2 bits of the offset matter; a narrow subtract
  // yields the same bits as the full 32-bit wrapped difference.
  logic [ADDR_W+1:0] w_byte_off;
  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_issue;
  logic              w_timeout;

  logic w_act_empty;
  logic w_act_pass;
  logic w_act_misalign;
  logic w_act_issue;
  logic w_act_done;
  logic w_act_timeout;
  logic w_act_wait;

  assign w_byte_off   = ALU_result_in[ADDR_W+1:0] - BASE_ADDR[ADDR_W+1:0];
  assign w_mem_op     = MEM_R_EN_in | MEM_W_EN_in;
  assign w_misaligned = (w_byte_off[1:0] != 2'b00);
  assign w_issue      = (r_state == c_IDLE) && valid_in && w_mem_op && !w_misaligned;
  assign w_timeout    = (r_state == c_ACCESS) && !mem_ack && (r_cnt == c_CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_issue) begin
          w_state_nxt = c_ACCESS;
        end
      end
      c_ACCESS: begin
        if (mem_ack || w_timeout) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / action decode; an ack in the final counted cycle beats timeout
  always_comb begin
    w_act_empty    = 1'b0;
    w_act_pass     = 1'b0;
    w_act_misalign = 1'b0;
    w_act_issue    = 1'b0;
    w_act_done     = 1'b0;
    w_act_timeout  = 1'b0;
    w_act_wait     = 1'b0;
    freeze         = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!valid_in) begin
          w_act_empty = 1'b1;
        end else if (!w_mem_op) begin
          w_act_pass = 1'b1;
        end else if (w_misaligned) begin
          w_act_misalign = 1'b1;
        end else begin
          w_act_issue = 1'b1;
          freeze      = 1'b1;
        end
      end
      c_ACCESS: begin
        if (mem_ack) begin
          w_act_done = 1'b1;
        end else if (w_timeout) begin
          w_act_timeout = 1'b1;
          freeze        = 1'b1;
        end else begin
          w_act_wait = 1'b1;
          freeze     = 1'b1;
        end
      end
      default: begin
        freeze = 1'b0;
      end
    endcase
  end

  // Timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_act_issue || w_act_done || w_act_timeout) begin
      r_cnt <= '0;
    end else if (w_act_wait) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // Memory interface and holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_h_wb    <= 1'b0;
      r_h_mr    <= 1'b0;
      r_h_alu   <= '0;
      r_h_dest  <= '0;
    end else if (w_act_issue) begin
      mem_req   <= 1'b1;
      mem_we    <= MEM_W_EN_in;
      mem_addr  <= w_byte_off[ADDR_W+1:2];
      mem_wdata <= ST_val_in;
      r_h_wb    <= WB_en_in;
      r_h_mr    <= MEM_R_EN_in & ~MEM_W_EN_in;
      r_h_alu   <= ALU_result_in;
      r_h_dest  <= Dest_in;
    end else if (w_act_done || w_act_timeout) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // MEM/WB registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out      <= 1'b0;
      WB_en          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      ALU_result     <= '0;
      Mem_read_value <= '0;
      Dest           <= '0;
    end else if (w_act_empty || w_act_issue) begin
      valid_out <= 1'b0;
      WB_en     <= 1'b0;
    end else if (w_act_pass) begin
      valid_out  <= 1'b1;
      WB_en      <= WB_en_in;
      MEM_R_EN   <= 1'b0;
      ALU_result <= ALU_result_in;
      Dest       <= Dest_in;
    end else if (w_act_misalign || w_act_timeout) begin
      valid_out <= 1'b1;
      WB_en     <= 1'b0;
    end else if (w_act_done) begin
      valid_out  <= 1'b1;
      WB_en      <= r_h_wb;
      MEM_R_EN   <= r_h_mr;
      ALU_result <= r_h_alu;
      Dest       <= r_h_dest;
      if (r_h_mr) begin
        Mem_read_value <= mem_rdata;
      end
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 2'b00;
    end else begin
      if (w_act_misalign) begin
        err[0] <= 1'b1;
      end
      if (w_act_timeout) begin
        err[1] <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register in the MIPS multicycle core.
- Takes the EXE results (ALU result, store value, control bits) and performs the data-memory access against a variable-latency memory using a req/ack handshake.
- Freezes upstream stages while an access is outstanding.
- Produces the registered MEM/WB-side values (WB_en, MEM_R_EN, ALU_result, Mem_read_value, Dest).

Parameters:
- ADDR_W, 10, word-address width driven to data memory
- BASE_ADDR, 1024, byte address mapped to memory word 0
- TIMEOUT, 15, max cycles waiting for mem_ack before abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  EXE/MEM register holds a live instruction
- WB_en_in  in  1  writeback enable from EXE
- MEM_R_EN_in  in  1  load
- MEM_W_EN_in  in  1  store
- ALU_result_in  in  32  effective byte address or ALU value
- ST_val_in  in  32  store data
- Dest_in  in  5  destination register
- freeze  out  1  stall EXE and earlier stages (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  write strobe, registered, valid with mem_req
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid when mem_ack=1
- valid_out  out  1  MEM/WB outputs hold a live instruction
- WB_en  out  1  registered
- MEM_R_EN  out  1  registered
- ALU_result  out  32  registered
- Mem_read_value  out  32  registered
- Dest  out  5  registered
- err  out  2  sticky: bit0 misaligned, bit1 timeout

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0 (valid_out, WB_en, MEM_R_EN, ALU_result, Mem_read_value, Dest, mem_req, mem_we, mem_addr, mem_wdata, err). FSM goes to IDLE and the timeout counter clears. If a reset lands mid-access, the access is dropped: mem_req falls immediately and a later mem_ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, valid_in=0: next edge valid_out=0 and WB_en=0; the other outputs hold.
- IDLE, valid_in=1, no memory op: passes through with 1-cycle latency. Next edge valid_out=1; WB_en, MEM_R_EN=0, ALU_result, Dest are copied; Mem_read_value holds.
- IDLE, valid_in=1, memory op:
  - Address computation: byte_off = ALU_result_in - BASE_ADDR (32-bit wrap); mem_addr = byte_off[ADDR_W+1:2], upper bits discarded.
  - Misaligned (byte_off[1:0]!=0): no request; set err[0]; next edge issues a bubble (valid_out=1, WB_en=0). freeze stays 0.
  - Aligned: freeze=1 in the same cycle. Next edge: mem_req=1, mem_we=MEM_W_EN_in, mem_addr/mem_wdata loaded, Dest/WB_en/ALU_result/MEM_R_EN latched into internal holding registers, valid_out=0, go to ACCESS.
- Read and write both set: write takes priority, mem_we=1, MEM_R_EN output=0.
- freeze is 1 whenever state=ACCESS, or when in IDLE with valid_in=1 and an aligned memory op present. It drops to 0 combinationally in the cycle mem_ack=1.
- ACCESS: mem_req held at 1 and the counter increments each cycle.
  - On mem_ack=1: next edge mem_req=0, outputs load from the holding registers, valid_out=1, Mem_read_value=mem_rdata for loads (held for stores), return to IDLE. Minimum memory op latency is 2 cycles from IDLE (ack in the first ACCESS cycle).
  - Timeout: if the counter reaches TIMEOUT with no ack, set err[1], drop mem_req, emit a bubble (valid_out=1, WB_en=0), return to IDLE.
  - mem_ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins.
  - mem_ack seen while in IDLE is ignored.
- err bits clear only on reset.
- Back-to-back memory ops: the new op is sampled in the IDLE cycle after completion; no request overlap.

Test Plan:
- Reset during ACCESS (mem_req=1) -> all outputs 0 in the same cycle; a mem_ack 2 cycles later is ignored; FSM stays IDLE.
- ALU op, valid_in=1, WB_en_in=1, ALU_result_in=0x0000_002A, Dest_in=5 -> next edge valid_out=1, WB_en=1, ALU_result=0x2A, Dest=5, freeze never 1.
- Load, ALU_result_in=1032, mem_ack after 3 ACCESS cycles with mem_rdata=0xDEADBEEF -> mem_addr=2, mem_we=0, freeze high for 4 cycles, then Mem_read_value=0xDEADBEEF, MEM_R_EN=1, valid_out=1.
- Store, ALU_result_in=1028, ST_val_in=0x1234, immediate ack -> mem_addr=1, mem_we=1, mem_wdata=0x1234, valid_out=1 two edges after issue, Mem_read_value unchanged.
- Load, ALU_result_in=1030 -> mem_req never asserts, err=2'b01, bubble with WB_en=0.
- Load with mem_ack never asserted -> mem_req drops after 15 ACCESS cycles, err=2'b10, bubble; a following ALU op passes through normally.
